pool_engine: RTL and testbench

POOL_ENGINE -- requirements
Module: pool_engine

---
 rtl/pool_engine.sv | 213 +++++++++++++++++++++
 tb/tb_pool_engine.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pool_engine.sv
`default_nettype none
// ============================================================================
// Module   : pool_engine
// Purpose  : Streaming max/average pooling over LANES parallel channels.
//            Each job processes win_num windows of win_len beats; after every
//            window the per-lane results are emitted one word at a time.
// Revision : 1.0 - initial release
// ============================================================================
module pool_engine #(
    parameter int LANES = 8,
    parameter int DW    = 16,
    parameter int CW    = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [1:0]            mode,
    input  logic                  relu,
    input  logic [CW-1:0]         win_len,
    input  logic [CW-1:0]         win_num,
    input  logic [15:0]           recip,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [LANES*DW-1:0]   in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DW-1:0]         out_data,
    output logic [7:0]            out_lane,
    output logic                  busy,
    output logic                  done
);

    localparam int c_ACW = DW + CW;          // accumulator width
    localparam int c_PW  = c_ACW + 17;       // product width (acc * unsigned Q0.16)
    localparam int c_AVW = c_ACW + 1;        // width of product >>> 16
    localparam int c_LW  = (LANES > 1) ? $clog2(LANES) : 1;

    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_RUN   = 2'd1;
    localparam logic [1:0] c_ST_DRAIN = 2'd2;
    localparam logic [1:0] c_ST_DONE  = 2'd3;

    localparam logic signed [c_AVW-1:0] c_SAT_MAX = {{(CW+2){1'b0}}, {(DW-1){1'b1}}};
    localparam logic signed [c_AVW-1:0] c_SAT_MIN = {{(CW+2){1'b1}}, {(DW-1){1'b0}}};

    logic [1:0]                r_state;
    logic [1:0]                w_next_state;

    // Job configuration captured at start
    logic                      r_avg;
    logic                      r_relu;
    logic [CW-1:0]             r_win_len;
    logic [CW-1:0]             r_win_num;
    logic [15:0]               r_recip;

    logic [CW-1:0]             r_elem_cnt;
    logic [CW-1:0]             r_win_cnt;
    logic signed [c_ACW-1:0]   r_acc [LANES];
    logic signed [c_ACW-1:0]   w_lane_ext [LANES];

    logic [c_LW-1:0]           r_lane;
    logic                      r_out_valid;
    logic [DW-1:0]             r_out_data;

    logic                      w_beat;
    logic                      w_first;
    logic                      w_last_elem;
    logic                      w_last_lane;
    logic                      w_xfer;
    logic                      w_win_end;
    logic                      w_last_win;
    logic [c_LW-1:0]           w_pick;
    logic signed [c_ACW-1:0]   w_acc_sel;
    logic signed [c_PW-1:0]    w_acc_wide;
    logic signed [c_PW-1:0]    w_rcp_wide;
    logic signed [c_PW-1:0]    w_prod;
    logic signed [c_AVW-1:0]   w_avg;
    logic signed [DW-1:0]      w_pre;
    logic [DW-1:0]             w_result;

    assign w_beat      = in_valid && in_ready;
    assign w_first     = (r_elem_cnt == '0);
    assign w_last_elem = (r_elem_cnt == (r_win_len - CW'(1)));
    assign w_last_lane = (r_lane == c_LW'(LANES - 1));
    assign w_xfer      = r_out_valid && out_ready;
    assign w_win_end   = (r_state == c_ST_DRAIN) && w_xfer && w_last_lane;
    assign w_last_win  = (({1'b0, r_win_cnt} + (CW+1)'(1)) == {1'b0, r_win_num});

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= c_ST_IDLE;
        else      r_state <= w_next_state;
    end

    // Next-state logic
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_ST_IDLE:  if (start) w_next_state = (win_num == '0) ? c_ST_DONE : c_ST_RUN;
            c_ST_RUN:   if (w_beat && w_last_elem) w_next_state = c_ST_DRAIN;
            c_ST_DRAIN: if (w_win_end) w_next_state = w_last_win ? c_ST_DONE : c_ST_RUN;
            default:    w_next_state = c_ST_IDLE;
        endcase
    end

    // State-decoded outputs
    always_comb begin
        in_ready = (r_state == c_ST_RUN);
        busy     = (r_state != c_ST_IDLE);
        done     = (r_state == c_ST_DONE);
    end

    // Capture job configuration; zero-length windows behave as length one
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_avg     <= 1'b0;
            r_relu    <= 1'b0;
            r_win_len <= '0;
            r_win_num <= '0;
            r_recip   <= '0;
        end else if (r_state == c_ST_IDLE && start) begin
            r_avg     <= (mode == 2'd1);
            r_relu    <= relu;
            r_win_len <= (win_len == '0) ? CW'(1) : win_len;
            r_win_num <= win_num;
            r_recip   <= recip;
        end
    end

    // Element and window counters
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_elem_cnt <= '0;
            r_win_cnt  <= '0;
        end else if (r_state == c_ST_DONE) begin
            r_elem_cnt <= '0;
            r_win_cnt  <= '0;
        end else begin
            if (w_beat) r_elem_cnt <= w_last_elem ? '0 : r_elem_cnt + CW'(1);
            if (w_win_end) r_win_cnt <= r_win_cnt + CW'(1);
        end
    end

    // Sign-extend each input lane to accumulator width
    always_comb begin
        for (int i = 0; i < LANES; i++) begin
            w_lane_ext[i] = {{CW{in_data[i*DW+DW-1]}}, in_data[i*DW +: DW]};
        end
    end

    // Per-lane accumulators: first beat loads, later beats max or add
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < LANES; i++) r_acc[i] <= '0;
        end else if (w_beat) begin
            for (int i = 0; i < LANES; i++) begin
                if (w_first)                      r_acc[i] <= w_lane_ext[i];
                else if (r_avg)                   r_acc[i] <= r_acc[i] + w_lane_ext[i];
                else if (w_lane_ext[i] > r_acc[i]) r_acc[i] <= w_lane_ext[i];
            end
        end
    end

    // Lane whose result is loaded into the output register next
    assign w_pick     = (r_out_valid && !w_last_lane) ? r_lane + c_LW'(1) : r_lane;
    assign w_acc_sel  = r_acc[w_pick];
    assign w_acc_wide = {{17{w_acc_sel[c_ACW-1]}}, w_acc_sel};
    assign w_rcp_wide = {{(c_ACW+1){1'b0}}, r_recip};
    assign w_prod     = w_acc_wide * w_rcp_wide;
    assign w_avg      = c_AVW'(w_prod >>> 16);

    // Result: floor-scaled average with saturation, or raw max; relu last
    always_comb begin
        w_pre = w_acc_sel[DW-1:0];
        if (r_avg) begin
            if (w_avg > c_SAT_MAX)      w_pre = {1'b0, {(DW-1){1'b1}}};
            else if (w_avg < c_SAT_MIN) w_pre = {1'b1, {(DW-1){1'b0}}};
            else                        w_pre = w_avg[DW-1:0];
        end
        w_result = (r_relu && w_pre[DW-1]) ? '0 : w_pre;
    end

    // Output register: one idle DRAIN cycle, then lanes in order on each accept
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_lane      <= '0;
        end else if (r_state == c_ST_DRAIN) begin
            if (!r_out_valid) begin
                r_out_valid <= 1'b1;
                r_out_data  <= w_result;
            end else if (out_ready) begin
                if (w_last_lane) begin
                    r_out_valid <= 1'b0;
                    r_lane      <= '0;
                end else begin
                    r_lane     <= r_lane + c_LW'(1);
                    r_out_data <= w_result;
                end
            end
        end else begin
            r_out_valid <= 1'b0;
            r_lane      <= '0;
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_lane  = 8'(r_lane);

endmodule
`default_nettype wire

// File: tb/tb_pool_engine.sv
`default_nettype none
// ============================================================================
// Module   : tb_pool_engine
// Purpose  : Scoreboard bench for pool_engine (LANES=4, DW=16, CW=8).
// Revision : 1.0 - initial release
// ============================================================================
module tb_pool_engine;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  mode = 2'd0;
    logic        relu = 1'b0;
    logic [7:0]  win_len = 8'd0;
    logic [7:0]  win_num = 8'd0;
    logic [15:0] recip = 16'd0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [63:0] in_data = 64'd0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [15:0] out_data;
    logic [7:0]  out_lane;
    logic        busy;
    logic        done;

    int n_checks = 0;
    int n_pass   = 0;
    int n_done   = 0;
    int exp_data[$];
    int exp_lane[$];
    bit stall_mode = 1'b0;
    bit prev_hold  = 1'b0;
    int prev_data  = 0;
    int prev_lane  = 0;

    pool_engine #(.LANES(4), .DW(16), .CW(8)) dut (
        .clk(clk), .rst(rst), .start(start), .mode(mode), .relu(relu),
        .win_len(win_len), .win_num(win_num), .recip(recip),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_lane(out_lane), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    // Output-ready driver: always ready, or alternating when stalling
    initial begin
        forever begin
            @(posedge clk);
            #1;
            out_ready = stall_mode ? !out_ready : 1'b1;
        end
    end

    // Monitor: pops the scoreboard on every accepted word
    always @(negedge clk) begin
        if (!rst) begin
            prev_hold = 1'b0;
        end else begin
            if (done) n_done++;
            if (prev_hold) begin
                check("hold_valid", int'(out_valid), 1);
                check("hold_data", int'($signed(out_data)), prev_data);
                check("hold_lane", int'(out_lane), prev_lane);
            end
            if (out_valid) begin
                check("in_ready_in_drain", int'(in_ready), 0);
                if (out_ready) begin
                    if (exp_data.size() == 0) begin
                        check("unexpected_output", 1, 0);
                    end else begin
                        check("out_data", int'($signed(out_data)), exp_data.pop_front());
                        check("out_lane", int'(out_lane), exp_lane.pop_front());
                    end
                end
            end
            prev_hold = out_valid && !out_ready;
            prev_data = int'($signed(out_data));
            prev_lane = int'(out_lane);
        end
    end

    task automatic expect4(input int e0, input int e1, input int e2, input int e3);
        exp_data.push_back(e0); exp_lane.push_back(0);
        exp_data.push_back(e1); exp_lane.push_back(1);
        exp_data.push_back(e2); exp_lane.push_back(2);
        exp_data.push_back(e3); exp_lane.push_back(3);
    endtask

    // Start a job, then scramble the config inputs (they must be ignored)
    task automatic start_job(input logic [1:0] m, input logic r, input int l,
                             input int n, input int rc);
        @(posedge clk); #1;
        mode = m; relu = r; win_len = 8'(l); win_num = 8'(n); recip = 16'(rc);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        mode = (m == 2'd1) ? 2'd0 : 2'd1;
        relu = ~r; win_len = 8'd1; win_num = 8'd7; recip = 16'd0;
    endtask

    task automatic send_beat(input int a0, input int a1, input int a2, input int a3);
        bit got = 1'b0;
        in_data  = {16'(a3), 16'(a2), 16'(a1), 16'(a0)};
        in_valid = 1'b1;
        for (int k = 0; k < 500; k++) begin
            @(negedge clk);
            if (in_ready) begin got = 1'b1; break; end
        end
        if (!got) check("in_ready_timeout", 0, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic finish_job();
        int d0 = n_done;
        for (int k = 0; k < 3000; k++) begin
            @(posedge clk);
            if (n_done != d0) break;
        end
        repeat (3) @(posedge clk);
        check("done_pulses", n_done - d0, 1);
        check("scoreboard_empty", exp_data.size(), 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("%0d/%0d checks passed", n_pass, n_checks + 1);
        $fatal(1);
    end

    initial begin
        int d_before;
        // Reset values
        repeat (3) @(negedge clk);
        check("rst_in_ready", int'(in_ready), 0);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_done", int'(done), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_out_data", int'(out_data), 0);
        check("rst_out_lane", int'(out_lane), 0);
        @(posedge clk); #1 rst = 1'b1;

        // Max pool, one window; also check the two-cycle output latency
        start_job(2'd0, 1'b0, 4, 1, 0);
        expect4(9, 4, -1, 32767);
        send_beat(3, 1, -1, -32768);
        send_beat(-7, 2, -2, 32767);
        send_beat(9, 3, -3, 0);
        send_beat(2, 4, -4, 0);
        @(negedge clk);
        check("lat_valid_c1", int'(out_valid), 0);
        check("lat_in_ready_c1", int'(in_ready), 0);
        check("lat_busy_c1", int'(busy), 1);
        @(negedge clk);
        check("lat_valid_c2", int'(out_valid), 1);
        finish_job();

        // Average, len 9, recip 7282: 90*7282=655380 -> 10; -655380 -> -11 (floor)
        start_job(2'd1, 1'b0, 9, 1, 7282);
        expect4(10, -11, 0, 100);
        for (int e = 0; e < 9; e++) send_beat(10, -10, 0, 100);
        finish_job();

        // Average, len 4, recip 16384: floor of sum/4
        start_job(2'd1, 1'b0, 4, 1, 16384);
        expect4(-6, 4, 2, -1);
        send_beat(-5, 4, 1, -1);
        send_beat(-5, 4, 2, 0);
        send_beat(-5, 4, 3, 0);
        send_beat(-6, 4, 4, 0);
        finish_job();

        // Same with relu: negative results clamp to 0
        start_job(2'd1, 1'b1, 4, 1, 16384);
        expect4(0, 4, 2, 0);
        send_beat(-5, 4, 1, -1);
        send_beat(-5, 4, 2, 0);
        send_beat(-5, 4, 3, 0);
        send_beat(-6, 4, 4, 0);
        finish_job();

        // Saturation, len 2, recip 65535
        start_job(2'd1, 1'b0, 2, 1, 65535);
        expect4(32767, -32768, 199, -2);
        send_beat(32767, -32768, 100, -1);
        send_beat(32767, -32768, 100, -1);
        finish_job();

        // Three windows, reserved mode 3 (max), out_ready alternating
        stall_mode = 1'b1;
        start_job(2'd3, 1'b0, 2, 3, 0);
        expect4(5, -2, 7, 0);
        send_beat(1, -3, 7, 0);
        send_beat(5, -2, 7, -1);
        expect4(10, -50, 4, 32767);
        send_beat(10, -100, 3, 32767);
        send_beat(-10, -50, 4, -32768);
        expect4(-1, 2, 0, 5);
        send_beat(-1, 2, 0, -5);
        send_beat(-1, 1, 0, 5);
        finish_job();
        stall_mode = 1'b0;

        // win_len 0 behaves as one element per window
        start_job(2'd0, 1'b0, 0, 1, 0);
        expect4(5, -6, 7, -8);
        send_beat(5, -6, 7, -8);
        finish_job();

        // Reset during the second window aborts without done
        start_job(2'd0, 1'b0, 2, 3, 0);
        expect4(2, 4, 6, 8);
        send_beat(1, 3, 5, 7);
        send_beat(2, 4, 6, 8);
        send_beat(9, 9, 9, 9);
        d_before = n_done;
        @(posedge clk); #2;
        rst = 1'b0;
        #1;
        check("abort_out_valid", int'(out_valid), 0);
        check("abort_busy", int'(busy), 0);
        check("abort_in_ready", int'(in_ready), 0);
        check("abort_done", int'(done), 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        check("abort_no_done", n_done - d_before, 0);
        check("abort_sb_empty", exp_data.size(), 0);

        // win_num 0: straight to DONE, no outputs
        d_before = n_done;
        start_job(2'd0, 1'b0, 2, 0, 0);
        @(negedge clk);
        check("zero_done_hi", int'(done), 1);
        @(negedge clk);
        check("zero_done_lo", int'(done), 0);
        check("zero_busy_lo", int'(busy), 0);
        repeat (5) @(posedge clk);
        check("zero_done_count", n_done - d_before, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
